// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch stage. Issues one instruction-memory read per
// instruction, holds the returned word for decode until it is accepted, then
// loads the externally selected next PC and (if enabled) starts the next read.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   enable          fetch enable; low stops new fetches from starting
//   next_pc         next PC from the PC-select mux, sampled at the decode handshake
//   im_req/im_addr  instruction-memory read request and byte address
//   im_ack/im_rdata instruction-memory acknowledge and read data
//   instr/instr_valid/instr_ready  fetched instruction to decode, with handshake
//   current_pc      address of the instruction being fetched or held
//   fetch_count     saturating count of instructions accepted by decode
//   pc_misalign     sticky flag: a misaligned next_pc was seen at a handshake
module pc_fetch #(
    parameter int unsigned DataSize = 32,
    parameter logic [9:0]  ResetPC  = 10'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [9:0]          next_pc,
    output logic                im_req,
    output logic [9:0]          im_addr,
    input  logic                im_ack,
    input  logic [DataSize-1:0] im_rdata,
    output logic [DataSize-1:0] instr,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [9:0]          current_pc,
    output logic [15:0]         fetch_count,
    output logic                pc_misalign
);

    localparam int unsigned PcW  = 10;
    localparam int unsigned CntW = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                im_req_q, im_req_d;
    logic [PcW-1:0]      im_addr_q, im_addr_d;
    logic [PcW-1:0]      current_pc_q, current_pc_d;
    logic [DataSize-1:0] instr_q, instr_d;
    logic                instr_valid_q, instr_valid_d;
    logic [CntW-1:0]     fetch_count_q, fetch_count_d;
    logic                pc_misalign_q, pc_misalign_d;
    logic [PcW-1:0]      aligned_pc_c;

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        im_req_d      = im_req_q;
        im_addr_d     = im_addr_q;
        current_pc_d  = current_pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fetch_count_d = fetch_count_q;
        pc_misalign_d = pc_misalign_q;
        // Low address bits are dropped; a misaligned PC only raises the flag.
        aligned_pc_c  = {next_pc[PcW-1:2], 2'b00};

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d   = S_REQ;
                    im_req_d  = 1'b1;
                    im_addr_d = current_pc_q;
                end
            end
            S_REQ: begin
                // The request runs to completion regardless of enable.
                if (im_ack) begin
                    state_d       = S_HOLD;
                    im_req_d      = 1'b0;
                    instr_d       = im_rdata;
                    instr_valid_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (instr_valid_q && instr_ready) begin
                    current_pc_d  = aligned_pc_c;
                    instr_valid_d = 1'b0;
                    if (fetch_count_q != {CntW{1'b1}}) begin
                        fetch_count_d = fetch_count_q + CntW'(1);
                    end
                    if (next_pc[1:0] != 2'b00) begin
                        pc_misalign_d = 1'b1;
                    end
                    // Back-to-back fetch skips IDLE to sustain one instr per 2 cycles.
                    if (enable) begin
                        state_d   = S_REQ;
                        im_req_d  = 1'b1;
                        im_addr_d = aligned_pc_c;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                im_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            im_req_q      <= 1'b0;
            im_addr_q     <= ResetPC;
            current_pc_q  <= ResetPC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            fetch_count_q <= '0;
            pc_misalign_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            im_req_q      <= im_req_d;
            im_addr_q     <= im_addr_d;
            current_pc_q  <= current_pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fetch_count_q <= fetch_count_d;
            pc_misalign_q <= pc_misalign_d;
        end
    end

    assign im_req      = im_req_q;
    assign im_addr     = im_addr_q;
    assign current_pc  = current_pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_count = fetch_count_q;
    assign pc_misalign = pc_misalign_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed scenarios plus randomized traffic for pc_fetch, checked
// against a transaction-level reference model and an instruction-memory
// scoreboard.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [9:0]  next_pc;
    logic        im_req;
    logic [9:0]  im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [9:0]  current_pc;
    logic [15:0] fetch_count;
    logic        pc_misalign;

    pc_fetch #(.DataSize(32), .ResetPC(10'd0)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .next_pc     (next_pc),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ack      (im_ack),
        .im_rdata    (im_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .current_pc  (current_pc),
        .fetch_count (fetch_count),
        .pc_misalign (pc_misalign)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a read is either outstanding, or a word is held for
    // decode, or neither.
    bit          m_outstanding;
    bit          m_holding;
    logic [9:0]  m_pc;
    logic [9:0]  m_addr;
    logic [31:0] m_instr;
    int unsigned m_count;
    bit          m_mis;

    logic [31:0] mem [256];

    function automatic void model_reset();
        m_outstanding = 1'b0;
        m_holding     = 1'b0;
        m_pc          = 10'd0;
        m_addr        = 10'd0;
        m_instr       = 32'd0;
        m_count       = 0;
        m_mis         = 1'b0;
    endfunction

    function automatic void model_edge(input logic en, input logic ack, input logic [31:0] rd,
                                       input logic rdy, input logic [9:0] npc);
        if (m_holding) begin
            if (rdy) begin
                m_holding = 1'b0;
                m_pc      = npc & 10'h3FC;
                m_count   = (m_count < 65535) ? m_count + 1 : 65535;
                if (npc % 4 != 0) m_mis = 1'b1;
                if (en) begin
                    m_outstanding = 1'b1;
                    m_addr        = m_pc;
                end
            end
        end else if (m_outstanding) begin
            if (ack) begin
                m_outstanding = 1'b0;
                m_holding     = 1'b1;
                m_instr       = rd;
            end
        end else if (en) begin
            m_outstanding = 1'b1;
            m_addr        = m_pc;
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".im_req"},      32'(im_req),      32'(m_outstanding));
        check({tag, ".im_addr"},     32'(im_addr),     32'(m_addr));
        check({tag, ".current_pc"},  32'(current_pc),  32'(m_pc));
        check({tag, ".instr"},       instr,            m_instr);
        check({tag, ".instr_valid"}, 32'(instr_valid), 32'(m_holding));
        check({tag, ".fetch_count"}, 32'(fetch_count), m_count);
        check({tag, ".pc_misalign"}, 32'(pc_misalign), 32'(m_mis));
    endtask

    // Apply inputs, advance one edge, update the model, sample 1 time unit later.
    task automatic step(input string tag, input logic en, input logic ack, input logic [31:0] rd,
                        input logic rdy, input logic [9:0] npc);
        enable      = en;
        im_ack      = ack;
        im_rdata    = rd;
        instr_ready = rdy;
        next_pc     = npc;
        @(posedge clk);
        model_edge(en, ack, rd, rdy, npc);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    logic [9:0]  tmp_pc;
    logic [9:0]  held_pc;
    logic [31:0] held_instr;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst = 1'b0; enable = 1'b0; next_pc = '0; im_ack = 1'b0;
        im_rdata = '0; instr_ready = 1'b0;
        #12;
        do_reset();

        // Streaming: ack and ready tied high, next_pc = pc + 4
        for (int i = 0; i < 11; i++) begin
            tmp_pc = m_pc + 10'd4;
            step("stream", 1'b1, 1'b1, 32'h1000 + 32'(i), 1'b1, tmp_pc);
        end
        check("stream_count5", 32'(fetch_count), 32'd5);
        check("stream_pc20", 32'(current_pc), 32'd20);

        // Delayed ack
        do_reset();
        step("dly_start", 1'b1, 1'b0, 32'h0, 1'b0, 10'h0);
        for (int i = 0; i < 3; i++) begin
            step("dly_wait", 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 10'h0);
            check("dly_req_stable", 32'(im_req), 32'd1);
        end
        step("dly_ack", 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 10'h0);
        check("dly_instr", instr, 32'hDEADBEEF);
        check("dly_valid", 32'(instr_valid), 32'd1);

        // Decode stall with next_pc toggling
        held_instr = instr;
        held_pc    = current_pc;
        for (int i = 0; i < 4; i++) begin
            step("stall", 1'b1, 1'b1, 32'h5555AAAA, 1'b0, 10'($urandom));
        end
        check("stall_instr", instr, held_instr);
        check("stall_pc", 32'(current_pc), 32'(held_pc));
        step("stall_hs", 1'b1, 1'b0, 32'h0, 1'b1, 10'h128);
        check("stall_hs_pc", 32'(current_pc), 32'h128);

        // Enable dropped during an outstanding request
        step("endrop_a", 1'b0, 1'b0, 32'h0, 1'b0, 10'h0);
        step("endrop_b", 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 10'h0);
        check("endrop_deliver", 32'(instr_valid), 32'd1);
        step("endrop_hold", 1'b0, 1'b0, 32'h0, 1'b0, 10'h0);
        step("endrop_hs", 1'b0, 1'b0, 32'h0, 1'b1, 10'h040);
        for (int i = 0; i < 3; i++) begin
            step("endrop_idle", 1'b0, 1'b1, 32'h0, 1'b1, 10'h0);
            check("endrop_noreq", 32'(im_req), 32'd0);
        end
        step("endrop_back", 1'b1, 1'b0, 32'h0, 1'b0, 10'h0);
        check("endrop_req_addr", 32'(im_addr), 32'h040);

        // Misaligned next_pc and wrap-around
        step("mis_ack", 1'b1, 1'b1, 32'h11111111, 1'b0, 10'h0);
        step("mis_hs", 1'b1, 1'b0, 32'h0, 1'b1, 10'h3FE);
        check("mis_pc", 32'(current_pc), 32'h3FC);
        check("mis_flag", 32'(pc_misalign), 32'd1);
        step("wrap_ack", 1'b1, 1'b1, 32'h22222222, 1'b0, 10'h0);
        step("wrap_hs", 1'b1, 1'b0, 32'h0, 1'b1, 10'h000);
        check("wrap_addr", 32'(im_addr), 32'h000);
        step("wrap_ack2", 1'b1, 1'b1, 32'h33333333, 1'b0, 10'h0);
        step("wrap_hs2", 1'b1, 1'b0, 32'h0, 1'b1, 10'h004);
        check("mis_sticky", 32'(pc_misalign), 32'd1);

        // Reset asserted mid-request, then a stray ack
        check("rst_pre_req", 32'(im_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("rst_async");
        im_ack = 1'b1; im_rdata = 32'hBAD0BAD0;
        @(posedge clk);
        #1;
        compare_all("rst_held");
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step("rst_stray_ack", 1'b0, 1'b1, 32'hBAD0BAD0, 1'b1, 10'h0);
            check("rst_no_valid", 32'(instr_valid), 32'd0);
        end
        step("rst_first_req", 1'b1, 1'b0, 32'h0, 1'b0, 10'h0);
        check("rst_first_req_hi", 32'(im_req), 32'd1);

        // Randomized traffic; memory returns mem[addr/4]
        for (int i = 0; i < 600; i++) begin
            logic en, ack, rdy;
            logic [9:0] npc;
            en  = ($urandom_range(0, 7) != 0);
            ack = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            npc = ($urandom_range(0, 15) == 0) ? 10'($urandom) : {8'($urandom), 2'b00};
            if (m_holding && rdy) begin
                check("sb_instr", instr, mem[m_pc[9:2]]);
            end
            step("rand", en, ack, mem[m_addr[9:2]], rdy, npc);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
